// File: rtl/change_payout_ctrl_pkg.sv
// Shared coin encodings, coin values in half-yuan units and payout FSM states.
package change_payout_ctrl_pkg;

    typedef enum logic [1:0] {
        CoinNone = 2'b00,
        CoinHalf = 2'b01,
        CoinOne  = 2'b10,
        CoinFive = 2'b11
    } coin_e;

    localparam logic [5:0] ValHalf = 6'd1;
    localparam logic [5:0] ValOne  = 6'd2;
    localparam logic [5:0] ValFive = 6'd10;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StReq,
        StGap,
        StFin,
        StFault
    } state_e;

    function automatic logic [5:0] coin_value(coin_e c);
        case (c)
            CoinHalf: return ValHalf;
            CoinOne:  return ValOne;
            CoinFive: return ValFive;
            default:  return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_payout_ctrl_if.sv
// Coin hopper dispense handshake: request + coin type out, one-cycle accept back.
interface change_payout_ctrl_if;
    import change_payout_ctrl_pkg::*;

    logic  dispense_req;
    coin_e dispense_type;
    logic  dispense_ack;

    modport master (output dispense_req, output dispense_type, input dispense_ack);
    modport slave  (input dispense_req, input dispense_type, output dispense_ack);

endinterface

// File: rtl/change_payout_ctrl_coin_stock_bank.sv
// Per-denomination coin stock counters with dispense decrement and refill load.
module change_payout_ctrl_coin_stock_bank
    import change_payout_ctrl_pkg::*;
#(
    parameter logic [7:0] STOCK5_INIT = 8'd20,
    parameter logic [7:0] STOCK1_INIT = 8'd50,
    parameter logic [7:0] STOCKH_INIT = 8'd50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dec,
    input  coin_e      dec_type,
    input  logic       refill,
    input  coin_e      refill_type,
    input  logic [7:0] refill_cnt,
    output logic       nz5,
    output logic       nz1,
    output logic       nzh
);

    logic [7:0] stock5_q, stock1_q, stockh_q;

    // A refill of the same type as a concurrent decrement overrides the decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            stock5_q <= STOCK5_INIT;
            stock1_q <= STOCK1_INIT;
            stockh_q <= STOCKH_INIT;
        end else begin
            if (refill && refill_type == CoinFive) begin
                stock5_q <= refill_cnt;
            end else if (dec && dec_type == CoinFive) begin
                stock5_q <= stock5_q - 8'd1;
            end
            if (refill && refill_type == CoinOne) begin
                stock1_q <= refill_cnt;
            end else if (dec && dec_type == CoinOne) begin
                stock1_q <= stock1_q - 8'd1;
            end
            if (refill && refill_type == CoinHalf) begin
                stockh_q <= refill_cnt;
            end else if (dec && dec_type == CoinHalf) begin
                stockh_q <= stockh_q - 8'd1;
            end
        end
    end

    assign nz5 = (stock5_q != 8'd0);
    assign nz1 = (stock1_q != 8'd0);
    assign nzh = (stockh_q != 8'd0);

endmodule

// File: rtl/change_payout_ctrl.sv
// Greedy change payout sequencer driving the coin hopper handshake.
// Optional ack timeout / fault state enabled by defining DISPENSE_TIMEOUT_EN.
module change_payout_ctrl
    import change_payout_ctrl_pkg::*;
#(
    parameter logic [7:0]  STOCK5_INIT = 8'd20,
    parameter logic [7:0]  STOCK1_INIT = 8'd50,
    parameter logic [7:0]  STOCKH_INIT = 8'd50,
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned ACK_TMO     = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [4:0]                  charge_val,
    input  logic                        charge_float,
    change_payout_ctrl_if.master        hopper,
    input  logic                        refill,
    input  logic [1:0]                  refill_type,
    input  logic [7:0]                  refill_cnt,
    output logic                        busy,
    output logic                        done,
    output logic                        short,
    output logic [5:0]                  remain_half,
    output logic                        fault
);

    localparam int GapW = $clog2(GAP_CYC + 1);

    if (GAP_CYC < 1 || ACK_TMO < 1) begin : g_bad_param
        $error("GAP_CYC and ACK_TMO must both be at least 1");
    end

    state_e            state_q, state_d;
    logic   [5:0]      amt_q, amt_d;
    coin_e             type_q, type_d;
    logic   [GapW-1:0] gap_q, gap_d;
    logic              short_q, short_d;
    logic   [5:0]      remain_q, remain_d;
    logic              dec;
    logic              nz5, nz1, nzh;

`ifdef DISPENSE_TIMEOUT_EN
    localparam int TmoW = $clog2(ACK_TMO + 1);
    logic [TmoW-1:0] tmo_q;
    logic            fault_pulse_q;
`endif

    change_payout_ctrl_coin_stock_bank #(
        .STOCK5_INIT (STOCK5_INIT),
        .STOCK1_INIT (STOCK1_INIT),
        .STOCKH_INIT (STOCKH_INIT)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .dec         (dec),
        .dec_type    (type_q),
        .refill      (refill),
        .refill_type (coin_e'(refill_type)),
        .refill_cnt  (refill_cnt),
        .nz5         (nz5),
        .nz1         (nz1),
        .nzh         (nzh)
    );

    always_comb begin
        state_d  = state_q;
        amt_d    = amt_q;
        type_d   = type_q;
        gap_d    = gap_q;
        short_d  = short_q;
        remain_d = remain_q;
        dec      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    amt_d    = {charge_val, charge_float};
                    short_d  = 1'b0;
                    remain_d = 6'd0;
                    state_d  = StSelect;
                end
            end
            StSelect: begin
                gap_d = '0;
                if (amt_q >= ValFive && nz5) begin
                    type_d  = CoinFive;
                    state_d = StReq;
                end else if (amt_q >= ValOne && nz1) begin
                    type_d  = CoinOne;
                    state_d = StReq;
                end else if (amt_q >= ValHalf && nzh) begin
                    type_d  = CoinHalf;
                    state_d = StReq;
                end else begin
                    type_d   = CoinNone;
                    short_d  = (amt_q != 6'd0);
                    remain_d = amt_q;
                    state_d  = StFin;
                end
            end
            StReq: begin
                if (hopper.dispense_ack) begin
                    amt_d   = amt_q - coin_value(type_q);
                    dec     = 1'b1;
                    state_d = StGap;
                end
`ifdef DISPENSE_TIMEOUT_EN
                else if (tmo_q == TmoW'(ACK_TMO - 1)) begin
                    short_d  = 1'b1;
                    remain_d = amt_q;
                    state_d  = StFault;
                end
`endif
            end
            StGap: begin
                if (gap_q == GapW'(GAP_CYC - 1)) begin
                    state_d = StSelect;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StFin:   state_d = StIdle;
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            amt_q    <= 6'd0;
            type_q   <= CoinNone;
            gap_q    <= '0;
            short_q  <= 1'b0;
            remain_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            amt_q    <= amt_d;
            type_q   <= type_d;
            gap_q    <= gap_d;
            short_q  <= short_d;
            remain_q <= remain_d;
        end
    end

`ifdef DISPENSE_TIMEOUT_EN
    // Counts cycles spent waiting in the current request; fault state is terminal.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q         <= '0;
            fault_pulse_q <= 1'b0;
        end else begin
            tmo_q         <= (state_q == StReq) ? tmo_q + 1'b1 : '0;
            fault_pulse_q <= (state_q == StReq) && (state_d == StFault);
        end
    end

    assign done  = (state_q == StFin) || fault_pulse_q;
    assign fault = (state_q == StFault);
`else
    assign done  = (state_q == StFin);
    assign fault = 1'b0;
`endif

    assign hopper.dispense_req  = (state_q == StReq);
    assign hopper.dispense_type = (state_q == StReq) ? type_q : CoinNone;
    assign busy                 = !(state_q == StIdle || state_q == StFin);
    assign short                = short_q;
    assign remain_half          = remain_q;

endmodule
